ai_ram_port_arbiter: RTL

Shares the single port of the AI weight/feature RAM between two requesters: the Avalon-ST loader, which writes one 32-bit word per packet beat with no backpressure, and the inference engine, which issues read/write requests over a req/gnt handshake. Loader writes are buffered in a small FIFO and take fixed priority. Engine reads are tracked through the RAM read latency and returned in order. The block sits between the loader/engine and the byte-lane RAM (4 × 8-bit lanes, 14-bit word address).

---
 rtl/ai_ram_pkg.sv | 19 +
 rtl/ai_ram_wr_fifo.sv | 61 ++++++
 rtl/ai_ram_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ai_ram_pkg.sv
// Shared types and defaults for the AI weight/feature RAM port.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ai_ram_pkg;

   localparam int AI_RAM_ADDR_W = 14;
   localparam int AI_RAM_RD_LAT = 1;

   typedef logic [31:0] ai_ram_word_t;
   typedef logic [3:0]  ai_ram_be_t;

   // Owner of the RAM port for the current cycle
   typedef enum logic [1:0] {
      SLOT_IDLE   = 2'd0,
      SLOT_LOADER = 2'd1,
      SLOT_ENGINE = 2'd2
   } slot_e;

endpackage

// File: rtl/ai_ram_wr_fifo.sv
// Loader write buffer: synchronous FIFO of {addr, data} entries.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: none; a push while full with no pop in the same cycle is dropped.
module ai_ram_wr_fifo
   import ai_ram_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = AI_RAM_ADDR_W + 32,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     pop_data,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign rd_en    = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign wr_en    = push && (!full || rd_en);
   assign pop_data = mem[rd_ptr];

   // Storage array; no reset needed since count gates what is visible
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

endmodule

// File: rtl/ai_ram_port_arbiter.sv
// Shares the AI RAM port: buffered loader writes at fixed priority, engine req/gnt otherwise.
// Latency: loader write on RAM 2 cycles after ld_write; engine access 1 cycle after gnt; read data RD_LAT+1 after gnt.
// Backpressure: loader is never stalled (overflow is flagged sticky); engine waits for eng_gnt.
module ai_ram_port_arbiter
   import ai_ram_pkg::*;
#(
   parameter int ADDR_W     = AI_RAM_ADDR_W,
   parameter int RD_LAT     = AI_RAM_RD_LAT,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_write,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   input  logic              eng_req,
   input  logic              eng_we,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic [31:0]       eng_wdata,
   input  logic [3:0]        eng_be,
   output logic              eng_gnt,
   output logic              eng_rvalid,
   output logic [31:0]       eng_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [3:0]        ram_be,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              busy,
   output logic              ld_overflow
);

   localparam int FW    = ADDR_W + 32;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [FW-1:0]    head;
   logic             fifo_empty;
   logic             fifo_full;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] count_nxt;
   logic             pop;
   logic             push_ok;
   logic             overflow_evt;
   slot_e            slot;
   logic             gnt_rd;
   logic [RD_LAT:0]  rd_sr;
   logic [RD_LAT:0]  rd_sr_nxt;

   // The head is drained whenever there is one; this is what gives the loader priority
   assign pop          = !fifo_empty;
   assign push_ok      = ld_write && (!fifo_full || pop);
   assign overflow_evt = ld_write && fifo_full && !pop;

   ai_ram_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FW),
      .CNT_W (CNT_W)
   ) u_wr_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ld_write),
      .push_data ({ld_addr, ld_data}),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // Slot owner: loader head first, engine only once the buffer is empty
   always_comb begin
      slot = SLOT_IDLE;
      if (pop) begin
         slot = SLOT_LOADER;
      end else if (eng_req && fifo_empty && !rst) begin
         slot = SLOT_ENGINE;
      end
   end

   assign eng_gnt = (slot == SLOT_ENGINE);
   assign gnt_rd  = eng_gnt && !eng_we;

   // Next state of the read tracker and of the buffer occupancy, used for busy
   always_comb begin
      rd_sr_nxt = {rd_sr[RD_LAT-1:0], gnt_rd};
      count_nxt = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
   end

   // RAM command registers; idle cycles keep address/data/enables stable
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_be    <= '0;
         ram_wdata <= '0;
      end else begin
         case (slot)
            SLOT_LOADER: begin
               ram_we    <= 1'b1;
               ram_addr  <= head[FW-1:32];
               ram_wdata <= head[31:0];
               ram_be    <= 4'hF;
            end
            SLOT_ENGINE: begin
               ram_we    <= eng_we;
               ram_addr  <= eng_addr;
               ram_wdata <= eng_wdata;
               ram_be    <= eng_we ? eng_be : 4'h0;
            end
            default: begin
               ram_we    <= 1'b0;
            end
         endcase
      end
   end

   // Read tracker, status and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sr       <= '0;
         busy        <= 1'b0;
         ld_overflow <= 1'b0;
      end else begin
         rd_sr <= rd_sr_nxt;
         busy  <= (count_nxt != '0) || (rd_sr_nxt != '0);
         if (overflow_evt) begin
            ld_overflow <= 1'b1;
         end
      end
   end

   assign eng_rvalid = rd_sr[RD_LAT];
   assign eng_rdata  = rd_sr[RD_LAT] ? ram_rdata : 32'h0;

endmodule
